// File: rtl/rot_dma_master.sv
// rot_dma_master
// AHB-lite bus master fed by core_set in the rotate datapath. It takes one
// burst command at a time and runs it as an INCR burst. Read bursts fill an
// internal data FIFO, and later write bursts drain that FIFO to the rotated
// destination.
//
// Ports
//   I_HCLK, I_HRESET_N        clock, asynchronous active-low reset
//   I_CMD_*                   burst command (valid, address, size, write, count)
//   O_DMA_READY               command handshake back to core_set
//   O_HADDR/HTRANS/HWRITE/
//   O_HSIZE/HBURST/HWDATA     AHB-lite master outputs (registered)
//   I_HRDATA/HREADY/HRESP     AHB-lite slave response
//   O_ERR                     sticky error flag (bus ERROR or oversize command)
//   O_LEVEL                   data FIFO occupancy
module rot_dma_master #(
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = 5
) (
    input  logic             I_HCLK,
    input  logic             I_HRESET_N,
    input  logic             I_CMD_VALID,
    input  logic [31:0]      I_CMD_ADDR,
    input  logic [2:0]       I_CMD_SIZE,
    input  logic             I_CMD_WRITE,
    input  logic [4:0]       I_CMD_COUNT,
    output logic             O_DMA_READY,
    output logic [31:0]      O_HADDR,
    output logic [1:0]       O_HTRANS,
    output logic             O_HWRITE,
    output logic [2:0]       O_HSIZE,
    output logic [2:0]       O_HBURST,
    output logic [31:0]      O_HWDATA,
    input  logic [31:0]      I_HRDATA,
    input  logic             I_HREADY,
    input  logic             I_HRESP,
    output logic             O_ERR,
    output logic [LVL_W-1:0] O_LEVEL
);

    localparam int          PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [31:0] DEPTH_U = FIFO_DEPTH;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_BURST,
        ST_LAST
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       haddr_q, haddr_d;
    logic [1:0]        htrans_q, htrans_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [4:0]        remain_q, remain_d;
    logic              dphase_q, dphase_d;
    logic              dwrite_q, dwrite_d;
    logic              err_q, err_d;
    logic              rdy_en_q, rdy_en_d;
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [31:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    logic [31:0] cnt32, lvl32, next_addr;
    logic        cmd_exec, push, pop, flush;

    // A command is executable when it either needs no bus activity (zero or
    // oversize count) or the FIFO can supply/absorb every beat of it.
    // Only the payload and internal state feed this, never I_HREADY.
    always_comb begin
        cnt32    = {27'd0, I_CMD_COUNT};
        lvl32    = 32'(level_q);
        cmd_exec = (cnt32 == 32'd0) || (cnt32 > DEPTH_U) ||
                   (I_CMD_WRITE ? (lvl32 >= cnt32) : ((DEPTH_U - lvl32) >= cnt32));
    end

    // rdy_en_q keeps the handshake low until the first clock after reset.
    assign O_DMA_READY = rdy_en_q && (state_q == ST_IDLE) && cmd_exec;
    assign next_addr   = haddr_q + (32'd1 << hsize_q);

    // Burst sequencer: an address phase is accepted on every I_HREADY=1 edge,
    // and its data phase runs in the following cycle(s). An ERROR response
    // withdraws the pending address phase at once and aborts the burst.
    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        remain_d = remain_q;
        dphase_d = dphase_q;
        dwrite_d = dwrite_q;
        err_d    = err_q;
        rdy_en_d = 1'b1;
        push     = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (I_CMD_VALID && O_DMA_READY) begin
                    if (cnt32 > DEPTH_U) begin
                        err_d = 1'b1;
                    end else if (cnt32 != 32'd0) begin
                        state_d  = ST_ADDR;
                        haddr_d  = I_CMD_ADDR;
                        htrans_d = TR_NONSEQ;
                        hwrite_d = I_CMD_WRITE;
                        hsize_d  = I_CMD_SIZE;
                        remain_d = I_CMD_COUNT - 5'd1;
                    end
                end
            end
            default: begin
                if (dphase_q && I_HRESP) begin
                    err_d    = 1'b1;
                    flush    = 1'b1;
                    htrans_d = TR_IDLE;
                    remain_d = 5'd0;
                    state_d  = ST_LAST;
                    if (I_HREADY) begin
                        state_d  = ST_IDLE;
                        dphase_d = 1'b0;
                    end
                end else if (I_HREADY) begin
                    if (dphase_q) begin
                        pop  = dwrite_q;
                        push = !dwrite_q;
                    end
                    if (state_q == ST_LAST) begin
                        state_d  = ST_IDLE;
                        dphase_d = 1'b0;
                    end else begin
                        dphase_d = 1'b1;
                        dwrite_d = hwrite_q;
                        if (remain_q != 5'd0) begin
                            // Crossing a 1KB boundary restarts the burst.
                            haddr_d  = next_addr;
                            htrans_d = (next_addr[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
                            remain_d = remain_q - 5'd1;
                            state_d  = ST_BURST;
                        end else begin
                            htrans_d = TR_IDLE;
                            state_d  = ST_LAST;
                        end
                    end
                end
            end
        endcase
    end

    // Data FIFO: read beats push, write beats pop, ERROR flushes everything.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else if (push && (lvl32 < DEPTH_U)) begin
            mem_d[wr_ptr_q] = I_HRDATA;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            level_d         = level_q + LVL_W'(1);
        end else if (pop && (level_q != '0)) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            level_d  = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            state_q  <= ST_IDLE;
            haddr_q  <= '0;
            htrans_q <= TR_IDLE;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            remain_q <= '0;
            dphase_q <= 1'b0;
            dwrite_q <= 1'b0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            remain_q <= remain_d;
            dphase_q <= dphase_d;
            dwrite_q <= dwrite_d;
            err_q    <= err_d;
            rdy_en_q <= rdy_en_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign O_HADDR  = haddr_q;
    assign O_HTRANS = htrans_q;
    assign O_HWRITE = hwrite_q;
    assign O_HSIZE  = hsize_q;
    assign O_HBURST = 3'b001;
    // FIFO head is stable for the whole write data phase; it only moves on pop.
    assign O_HWDATA = mem_q[rd_ptr_q];
    assign O_ERR    = err_q;
    assign O_LEVEL  = level_q;

endmodule

// File: tb/tb_rot_dma_master.sv
// tb_rot_dma_master
// Drives burst commands into rot_dma_master and plays an AHB-lite slave.
// Expected bus beats and write data are queued when a command is accepted;
// the negedge monitor pops and compares them as the DUT presents transfers.
module tb_rot_dma_master;

    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        int          idx;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic        cmd_write;
    logic [4:0]  cmd_count;
    logic        dma_ready;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic        err;
    logic [4:0]  level;

    rot_dma_master #(.FIFO_DEPTH(DEPTH), .LVL_W(5)) dut (
        .I_HCLK      (clk),
        .I_HRESET_N  (rst_n),
        .I_CMD_VALID (cmd_valid),
        .I_CMD_ADDR  (cmd_addr),
        .I_CMD_SIZE  (cmd_size),
        .I_CMD_WRITE (cmd_write),
        .I_CMD_COUNT (cmd_count),
        .O_DMA_READY (dma_ready),
        .O_HADDR     (haddr),
        .O_HTRANS    (htrans),
        .O_HWRITE    (hwrite),
        .O_HSIZE     (hsize),
        .O_HBURST    (hburst),
        .O_HWDATA    (hwdata),
        .I_HRDATA    (hrdata),
        .I_HREADY    (hready),
        .I_HRESP     (hresp),
        .O_ERR       (err),
        .O_LEVEL     (level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    beat_t       exp_beats[$];
    logic [31:0] exp_wdata[$];
    logic [31:0] model_fifo[$];
    logic        model_err = 1'b0;

    // Slave behaviour for the current command
    int wait_beat = -1;
    int wait_n    = 0;
    int err_beat  = -1;

    // Monitor state
    logic        dp_valid = 1'b0;
    logic        dp_write = 1'b0;
    int          dp_idx   = 0;
    int          waits    = 0;
    int          err_cyc  = 0;
    logic        held_valid = 1'b0;
    logic [31:0] held_addr;
    logic [1:0]  held_trans;
    logic [31:0] held_wdata;
    logic        held_wr;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: actual=event required=no event", name);
    endtask

    function automatic void clearModel();
        exp_beats.delete();
        exp_wdata.delete();
        model_fifo.delete();
        model_err = 1'b0;
        wait_beat = -1;
        err_beat  = -1;
    endfunction

    // Beat k lives at start + k*bytes; the first beat and any beat landing
    // on a 1KB boundary start a new NONSEQ sequence.
    function automatic void modelCommand(input logic [31:0] a, input logic [2:0] s,
                                         input logic w, input int cnt);
        beat_t b;
        logic [31:0] ba;
        if (cnt > DEPTH) begin
            model_err = 1'b1;
        end else begin
            for (int k = 0; k < cnt; k++) begin
                ba      = a + k * (1 << s);
                b.addr  = ba;
                b.trans = (k == 0 || (ba & 32'h3FF) == 0) ? 2'b10 : 2'b11;
                b.wr    = w;
                b.size  = s;
                b.idx   = k;
                exp_beats.push_back(b);
                if (w) exp_wdata.push_back(model_fifo.pop_front());
            end
        end
    endfunction

    // AHB slave and scoreboard monitor, evaluated mid-cycle.
    always @(negedge clk) begin : monitor
        logic  hr;
        logic  he;
        logic [31:0] d;
        beat_t b;
        if (!rst_n) begin
            dp_valid   = 1'b0;
            held_valid = 1'b0;
            err_cyc    = 0;
            waits      = 0;
            hready     = 1'b1;
            hresp      = 1'b0;
            hrdata     = '0;
        end else begin
            if (held_valid) begin
                checkOutput("hold_haddr", haddr, held_addr);
                checkOutput("hold_htrans", {30'd0, htrans}, {30'd0, held_trans});
                if (held_wr) checkOutput("hold_hwdata", hwdata, held_wdata);
            end
            held_valid = 1'b0;
            hr = 1'b1;
            he = 1'b0;
            if (dp_valid) begin
                if (dp_idx == err_beat) begin
                    he = 1'b1;
                    if (err_cyc == 0) begin
                        hr = 1'b0;
                        err_cyc = 1;
                    end else begin
                        err_cyc = 0;
                    end
                end else if (dp_idx == wait_beat && waits < wait_n) begin
                    hr = 1'b0;
                    waits++;
                end
            end
            hready = hr;
            hresp  = he;
            hrdata = $urandom;
            if (dp_valid && hr && he) begin
                checkOutput("err_htrans_idle", {30'd0, htrans}, 32'd0);
                exp_beats.delete();
                exp_wdata.delete();
                model_fifo.delete();
                model_err = 1'b1;
                err_beat  = -1;
                dp_valid  = 1'b0;
            end else begin
                if (dp_valid && hr) begin
                    if (dp_write) begin
                        if (exp_wdata.size() == 0) failNow("unexpected_wdata");
                        else checkOutput("hwdata", hwdata, exp_wdata.pop_front());
                    end else begin
                        d = $urandom;
                        hrdata = d;
                        model_fifo.push_back(d);
                    end
                end
                if (!hr && !he && (htrans != 2'b00 || dp_valid)) begin
                    held_valid = 1'b1;
                    held_addr  = haddr;
                    held_trans = htrans;
                    held_wdata = hwdata;
                    held_wr    = dp_valid && dp_write;
                end
                if (hr) begin
                    if (htrans != 2'b00) begin
                        if (exp_beats.size() == 0) begin
                            failNow("unexpected_beat");
                            dp_idx = -99;
                        end else begin
                            b = exp_beats.pop_front();
                            checkOutput("haddr", haddr, b.addr);
                            checkOutput("htrans", {30'd0, htrans}, {30'd0, b.trans});
                            checkOutput("hwrite", {31'd0, hwrite}, {31'd0, b.wr});
                            checkOutput("hsize", {29'd0, hsize}, {29'd0, b.size});
                            dp_idx = b.idx;
                        end
                        dp_valid = 1'b1;
                        dp_write = hwrite;
                        waits    = 0;
                    end else begin
                        dp_valid = 1'b0;
                    end
                end
            end
        end
    end

    // Present a command and hold it until the DUT accepts it.
    task automatic applyStimulus(input logic [31:0] a, input logic [2:0] s, input logic w,
                                 input int cnt, input int wb, input int wn, input int eb);
        int t = 0;
        @(negedge clk); #2;
        cmd_addr  = a;
        cmd_size  = s;
        cmd_write = w;
        cmd_count = 5'(cnt);
        cmd_valid = 1'b1;
        #1;
        while (!dma_ready && t < 300) begin
            @(negedge clk); #3;
            t++;
        end
        if (!dma_ready) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
        end else begin
            wait_beat = wb;
            wait_n    = wn;
            err_beat  = eb;
            modelCommand(a, s, w, cnt);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic waitIdle();
        int t = 0;
        @(negedge clk); #2;
        while ((exp_beats.size() != 0 || dp_valid || htrans != 2'b00) && t < 400) begin
            @(negedge clk); #2;
            t++;
        end
        if (t >= 400) checkOutput("idle_timeout", 32'd1, 32'd0);
        @(negedge clk); #2;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_level"}, {27'd0, level}, 32'(model_fifo.size()));
        checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, model_err});
    endtask

    task automatic releaseReset();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_count = 5'd4;
        cmd_size  = 3'd2;
        @(negedge clk); #2;
        rst_n = 1'b1;
        #1;
        checkOutput("ready_before_clock", {31'd0, dma_ready}, 32'd0);
        @(posedge clk); #1;
        checkOutput("ready_after_release", {31'd0, dma_ready}, 32'd1);
    endtask

    task automatic resetMid(input string tag);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkOutput({tag, "_htrans"}, {30'd0, htrans}, 32'd0);
        checkOutput({tag, "_level"}, {27'd0, level}, 32'd0);
        checkOutput({tag, "_ready"}, {31'd0, dma_ready}, 32'd0);
        checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
        clearModel();
        releaseReset();
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        int lvl;
        int cnt;
        logic [2:0]  s;
        logic        w;
        logic [31:0] a;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_size  = '0;
        cmd_write = 1'b0;
        cmd_count = '0;
        #1;
        checkOutput("rst_htrans", {30'd0, htrans}, 32'd0);
        checkOutput("rst_haddr", haddr, 32'd0);
        checkOutput("rst_hburst", {29'd0, hburst}, 32'd1);
        checkOutput("rst_hwdata", hwdata, 32'd0);
        checkOutput("rst_ready", {31'd0, dma_ready}, 32'd0);
        checkOutput("rst_level", {27'd0, level}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        releaseReset();

        $display("[TB] reset during beat 3 of a read burst");
        applyStimulus(32'h0000_0100, 3'd2, 1'b0, 8, -1, 0, -1);
        t = 0;
        while (exp_beats.size() > 4 && t < 100) begin
            @(negedge clk); #2;
            t++;
        end
        checkOutput("mid_reset_beat3_reached", 32'(exp_beats.size()), 32'd4);
        resetMid("mid_reset");

        $display("[TB] read 8 words at 0x1000");
        applyStimulus(32'h0000_1000, 3'd2, 1'b0, 8, -1, 0, -1);
        t = 0;
        do begin
            @(negedge clk); #2;
            t++;
        end while (!dma_ready && t < 50);
        checkOutput("ready_latency", 32'(t), 32'd10);
        waitIdle();
        checkState("read8");

        $display("[TB] write 8 words at 0x2000");
        applyStimulus(32'h0000_2000, 3'd2, 1'b1, 8, -1, 0, -1);
        waitIdle();
        checkState("write8");

        $display("[TB] read 4 words across 1KB boundary with wait states");
        applyStimulus(32'h0000_03F8, 3'd2, 1'b0, 4, 1, 2, -1);
        waitIdle();
        checkState("read4_wait");

        $display("[TB] write larger than FIFO level is held off");
        @(negedge clk); #2;
        cmd_write = 1'b1;
        cmd_count = 5'd8;
        cmd_addr  = 32'h0000_4000;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("reject_ready", {31'd0, dma_ready}, 32'd0);
            checkOutput("reject_htrans", {30'd0, htrans}, 32'd0);
            @(negedge clk); #2;
        end
        cmd_valid = 1'b0;
        applyStimulus(32'h0000_5000, 3'd2, 1'b0, 4, -1, 0, -1);
        waitIdle();
        checkState("refill");
        applyStimulus(32'h0000_6000, 3'd2, 1'b1, 8, -1, 0, -1);
        waitIdle();
        checkState("drain");

        $display("[TB] zero-count and oversize commands");
        applyStimulus(32'h0000_7000, 3'd2, 1'b0, 0, -1, 0, -1);
        @(negedge clk); #2;
        checkOutput("count0_ready", {31'd0, dma_ready}, 32'd1);
        checkState("count0");
        applyStimulus(32'h0000_7000, 3'd1, 1'b0, 20, -1, 0, -1);
        waitIdle();
        checkState("oversize");
        resetMid("err_clear");

        $display("[TB] ERROR response on beat 2 of a read burst");
        applyStimulus(32'h0000_8000, 3'd2, 1'b0, 8, -1, 0, 2);
        waitIdle();
        checkState("bus_err");
        checkOutput("bus_err_ready", {31'd0, dma_ready}, 32'd1);
        applyStimulus(32'h0000_9000, 3'd1, 1'b0, 4, -1, 0, -1);
        waitIdle();
        checkState("after_err_read");
        applyStimulus(32'h0000_A000, 3'd0, 1'b1, 4, 2, 1, -1);
        waitIdle();
        checkState("after_err_write");

        $display("[TB] randomized commands");
        for (int n = 0; n < 40; n++) begin
            lvl = model_fifo.size();
            s   = 3'($urandom_range(0, 2));
            w   = (lvl > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            if ($urandom_range(0, 9) == 0) cnt = $urandom_range(17, 31);
            else if (w) cnt = $urandom_range(0, lvl);
            else cnt = $urandom_range(0, DEPTH - lvl);
            if ($urandom_range(0, 1) == 1)
                a = 32'($urandom_range(1, 1000)) * 32'h400 - (32'($urandom_range(1, 6)) << s);
            else
                a = $urandom & 32'h0FFF_FFFF;
            a = a & ~((32'd1 << s) - 32'd1);
            applyStimulus(a, s, w, cnt, $urandom_range(0, 16), $urandom_range(0, 3), -1);
            waitIdle();
            checkState("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rot_dma_master.md
Name: rot_dma_master

Overview:
- AHB-lite bus master sitting directly downstream of core_set in the rotate datapath.
- Accepts one burst command at a time (address, beat size, direction, beat count) from core_set, which drives it from its O_ADDR/O_SIZE/O_WRITE/O_COUNT outputs.
- Executes the command as an INCR burst on AHB. Read data is buffered in an internal FIFO; later write bursts drain the FIFO to the rotated destination.
- Returns O_DMA_READY to core_set as the command handshake.

Parameters:
FIFO_DEPTH, 16, data FIFO entries (power of 2, >=2)
LVL_W, 5, FIFO level width = log2(FIFO_DEPTH)+1

Ports:
I_HCLK  in  1  clock
I_HRESET_N  in  1  async active-low reset
I_CMD_VALID  in  1  command present
I_CMD_ADDR  in  32  burst start byte address
I_CMD_SIZE  in  3  beat size, HSIZE encoding (0 byte, 1 half, 2 word; others illegal)
I_CMD_WRITE  in  1  1=write burst from FIFO, 0=read burst into FIFO
I_CMD_COUNT  in  5  beats in burst
O_DMA_READY  out  1  command accepted when I_CMD_VALID & O_DMA_READY
O_HADDR  out  32  AHB address
O_HTRANS  out  2  IDLE=0, NONSEQ=2, SEQ=3
O_HWRITE  out  1  AHB direction
O_HSIZE  out  3  AHB size
O_HBURST  out  3  always INCR (3'b001)
O_HWDATA  out  32  write data
I_HRDATA  in  32  read data
I_HREADY  in  1  transfer complete / wait
I_HRESP  in  1  0 OKAY, 1 ERROR
O_ERR  out  1  sticky error flag
O_LEVEL  out  LVL_W  FIFO occupancy

Behaviour:
- Reset (async, any time incl. mid-burst): all outputs 0. O_HTRANS=IDLE, O_HBURST=3'b001, O_DMA_READY=0 during reset and 1 on the first clock after release. FIFO emptied, O_ERR=0, FSM=IDLE.
- FSM states:
  - IDLE.
  - ADDR: NONSEQ address phase.
  - BURST: SEQ address phases, overlapped with prior data phase.
  - LAST: final data phase only.
  - All bus outputs are registered.
- O_DMA_READY=1 only in IDLE and only when the command is executable:
  - read: FIFO_DEPTH-level >= count.
  - write: level >= count.
  - O_DMA_READY depends on command payload; no combinational path from I_HREADY.
- Command accepted in cycle N: first NONSEQ appears on O_HADDR/O_HTRANS in cycle N+1. O_DMA_READY drops in N+1.
- Address of beat k = start + k*(1<<size). 32-bit wrap ignored.
- Beat whose address is a 1KB boundary (addr[9:0]==0, k>0) is issued as NONSEQ, not SEQ.
- I_HREADY low: hold O_HADDR, O_HTRANS, O_HWDATA. No FIFO push/pop; no address advance.
- Read data phase with I_HREADY=1, I_HRESP=0: push I_HRDATA. Unused upper lanes are pushed as-is.
- Write data phase: O_HWDATA = FIFO head, valid throughout the data phase. Pop when I_HREADY=1.
- After the last data phase completes, return to IDLE. O_DMA_READY is high the following cycle, so commands run back-to-back with one idle bus cycle between them.
- I_HRESP=1 in any data phase:
  - set O_ERR (sticky until reset);
  - next address phase is IDLE and remaining beats are dropped;
  - FIFO is flushed;
  - return to IDLE once the current data phase completes.
- Command count=0: accepted, no bus activity, O_DMA_READY back high next cycle.
- Command count>FIFO_DEPTH: accepted, no bus activity, O_ERR set.
- Simultaneous push/pop cannot occur (single command in flight). O_LEVEL never exceeds FIFO_DEPTH and never underflows.

Test Plan:
- Reset mid-burst (assert I_HRESET_N=0 between clocks during beat 3) -> O_HTRANS=0 and O_LEVEL=0 immediately (asynchronous); O_DMA_READY=1 first cycle after release.
- Read 8 words @0x1000, I_HREADY=1 -> HADDR 0x1000..0x101C; HTRANS NONSEQ then 7 SEQ, then IDLE; O_LEVEL=8; O_DMA_READY high 10 cycles after acceptance.
- Write 8 words @0x2000 after previous -> HWDATA order equals read order; O_LEVEL 8->0; HWRITE=1 in all address phases.
- Read 4 words @0x3F8, HREADY low 2 cycles on beat 1 -> HADDR/HTRANS held 2 cycles; beat 2 (0x400) is NONSEQ; exactly 4 pushes.
- Level=4, write count=8 -> O_DMA_READY=0, no bus activity; read 4 accepted; then write 8 accepted, level 0.
- HRESP=1 on beat 2 of 8-beat read -> next HTRANS IDLE, O_ERR=1, O_LEVEL=0, O_DMA_READY=1; O_ERR stays 1 through later good commands.
